// File: rtl/mips_cpu_bus.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_bus
// Purpose  : Multi-cycle MIPS-I subset CPU on a shared Avalon-style bus.
//            FETCH -> EXEC -> (MEM -> (WB)) -> FETCH, one branch delay slot,
//            halts when control reaches address 0.
// Revision : 1.0 - initial release
// ============================================================================
module mips_cpu_bus #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC  = 3'd1,
    S_MEM   = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04, OP_BNE  = 6'h05, OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D, OP_XORI = 6'h0E, OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23, OP_SW   = 6'h2B;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, target_q, target_d;
  logic        pend_q, pend_d;
  logic [31:0] gpr_q [32];
  logic [31:0] gpr_d [32];

  logic [31:0] ir, imm_s, imm_z, rs_val, rt_val, pc_seq, npc, mem_addr;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic        is_lw, is_sw;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  assign active      = (state_q != S_HALT);
  assign register_v0 = gpr_q[2];
  assign byteenable  = 4'b1111;

  // Field decode; in EXEC the instruction is still on readdata, later it is held in instr_q.
  always_comb begin
    ir       = (state_q == S_EXEC) ? readdata : instr_q;
    op       = ir[31:26];
    rs       = ir[25:21];
    rt       = ir[20:16];
    rd       = ir[15:11];
    shamt    = ir[10:6];
    funct    = ir[5:0];
    imm_s    = {{16{ir[15]}}, ir[15:0]};
    imm_z    = {16'h0000, ir[15:0]};
    rs_val   = gpr_q[rs];
    rt_val   = gpr_q[rt];
    pc_seq   = pc_q + 32'd4;
    npc      = pend_q ? target_q : pc_seq;
    mem_addr = rs_val + imm_s;
    is_lw    = (op == OP_LW);
    is_sw    = (op == OP_SW);
  end

  // Next-state, bus outputs, ALU and register writeback.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    pend_d    = pend_q;
    target_d  = target_q;
    wb_en     = 1'b0;
    wb_addr   = 5'd0;
    wb_data   = 32'd0;
    read      = 1'b0;
    write     = 1'b0;
    address   = pc_q;
    writedata = rt_val;
    gpr_d     = gpr_q;

    case (state_q)
      S_FETCH: begin
        read = reset;  // drop the request as soon as reset is asserted
        if (!waitrequest) state_d = S_EXEC;
      end
      S_EXEC: begin
        instr_d = ir;
        pc_d    = npc;
        pend_d  = 1'b0;  // any pending target is consumed by this delay slot
        case (op)
          OP_SPECIAL: begin
            wb_addr = rd;
            wb_en   = 1'b1;
            case (funct)
              6'h21: wb_data = rs_val + rt_val;
              6'h23: wb_data = rs_val - rt_val;
              6'h24: wb_data = rs_val & rt_val;
              6'h25: wb_data = rs_val | rt_val;
              6'h26: wb_data = rs_val ^ rt_val;
              6'h27: wb_data = ~(rs_val | rt_val);
              6'h2A: wb_data = {31'd0, $signed(rs_val) < $signed(rt_val)};
              6'h2B: wb_data = {31'd0, rs_val < rt_val};
              6'h00: wb_data = rt_val << shamt;
              6'h02: wb_data = rt_val >> shamt;
              6'h03: wb_data = $signed(rt_val) >>> shamt;
              6'h04: wb_data = rt_val << rs_val[4:0];
              6'h06: wb_data = rt_val >> rs_val[4:0];
              6'h07: wb_data = $signed(rt_val) >>> rs_val[4:0];
              6'h08: begin
                wb_en    = 1'b0;
                pend_d   = 1'b1;
                target_d = rs_val;
              end
              6'h09: begin
                wb_data  = pc_q + 32'd8;
                pend_d   = 1'b1;
                target_d = rs_val;
              end
              default: wb_en = 1'b0;
            endcase
          end
          OP_ADDIU: begin wb_en = 1'b1; wb_addr = rt; wb_data = rs_val + imm_s; end
          OP_ANDI:  begin wb_en = 1'b1; wb_addr = rt; wb_data = rs_val & imm_z; end
          OP_ORI:   begin wb_en = 1'b1; wb_addr = rt; wb_data = rs_val | imm_z; end
          OP_XORI:  begin wb_en = 1'b1; wb_addr = rt; wb_data = rs_val ^ imm_z; end
          OP_SLTI:  begin wb_en = 1'b1; wb_addr = rt; wb_data = {31'd0, $signed(rs_val) < $signed(imm_s)}; end
          OP_SLTIU: begin wb_en = 1'b1; wb_addr = rt; wb_data = {31'd0, rs_val < imm_s}; end
          OP_LUI:   begin wb_en = 1'b1; wb_addr = rt; wb_data = {ir[15:0], 16'h0000}; end
          OP_BEQ, OP_BNE: begin
            if ((rs_val == rt_val) == (op == OP_BEQ)) begin
              pend_d   = 1'b1;
              target_d = pc_seq + (imm_s << 2);
            end
          end
          OP_J, OP_JAL: begin
            pend_d   = 1'b1;
            target_d = {pc_seq[31:28], ir[25:0], 2'b00};
            if (op == OP_JAL) begin
              wb_en   = 1'b1;
              wb_addr = 5'd31;
              wb_data = pc_q + 32'd8;
            end
          end
          default: ;
        endcase
        if (is_lw || is_sw) state_d = S_MEM;
        else                state_d = (npc == 32'd0) ? S_HALT : S_FETCH;
      end
      S_MEM: begin
        address = mem_addr & ~32'd3;
        read    = is_lw & reset;
        write   = is_sw & reset;
        if (!waitrequest) begin
          if (is_lw) state_d = S_WB;
          else       state_d = (pc_q == 32'd0) ? S_HALT : S_FETCH;
        end
      end
      S_WB: begin
        wb_en   = 1'b1;
        wb_addr = rt;
        wb_data = readdata;
        state_d = (pc_q == 32'd0) ? S_HALT : S_FETCH;
      end
      default: ;  // S_HALT: idle until reset
    endcase

    if (wb_en && (wb_addr != 5'd0)) gpr_d[wb_addr] = wb_data;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_VECTOR;
      instr_q  <= 32'd0;
      pend_q   <= 1'b0;
      target_q <= 32'd0;
      for (int i = 0; i < 32; i++) gpr_q[i] <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pend_q   <= pend_d;
      target_q <= target_d;
      gpr_q    <= gpr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_bus.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_cpu_bus
// Purpose  : Self-checking bench for mips_cpu_bus using a table of small
//            hand-assembled programs plus a mid-run reset sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_cpu_bus;

  localparam logic [31:0] RV = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        active, write, read, waitrequest;
  logic [31:0] register_v0, address, writedata;
  logic [31:0] readdata = 32'd0;
  logic [3:0]  byteenable;

  mips_cpu_bus #(.RESET_VECTOR(RV)) dut (
    .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
    .address(address), .write(write), .read(read), .waitrequest(waitrequest),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Memory model: 16 words at RV, one-cycle read latency, programmable stall.
  logic [31:0]        mem [16];
  logic [15:0][31:0]  image;
  logic               load = 1'b0;
  int                 stall_n = 0;
  int                 wcnt = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] off;
    off = a - RV;
    if (off < 32'd64) return mem[off[5:2]];
    return 32'd0;
  endfunction

  assign waitrequest = (read || write) && (wcnt < stall_n);

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 16; i++) mem[i] <= image[i];
    end else if (write && !waitrequest) begin
      if ((address - RV) < 32'd64) mem[(address - RV) >> 2] <= writedata;
    end
    if (read && !waitrequest) readdata <= mem_rd(address);
    if ((read || write) && waitrequest) wcnt <= wcnt + 1;
    else                                wcnt <= 0;
  end

  // Bus protocol monitor: held request during stalls, byte lanes, exclusive read/write.
  logic        prev_wait = 1'b0, prev_read = 1'b0, prev_write = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  always @(negedge clk) begin
    if (reset && prev_wait && (prev_read || prev_write)) begin
      check("stall_addr",  address, prev_addr);
      check("stall_read",  {31'd0, read},  {31'd0, prev_read});
      check("stall_write", {31'd0, write}, {31'd0, prev_write});
    end
    if (write) check("byteenable", {28'd0, byteenable}, 32'h0000000F);
    if (read || write) check("rw_exclusive", {31'd0, read && write}, 32'd0);
    prev_wait  = waitrequest && reset;
    prev_read  = read;
    prev_write = write;
    prev_addr  = address;
  end

  typedef struct {
    string             name;
    logic [15:0][31:0] prog;
    logic [31:0]       exp_v0;
    int                stall;
  } vec_t;

  vec_t tbl [7];

  task automatic wait_halt(input string name, input int limit);
    int n;
    n = 0;
    while (active === 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({name, "_halted"}, {31'd0, active}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    image   = v.prog;
    stall_n = v.stall;
    load    = 1'b1;
    reset   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    check({v.name, "_rst_read"},   {31'd0, read},   32'd0);
    check({v.name, "_rst_write"},  {31'd0, write},  32'd0);
    check({v.name, "_rst_active"}, {31'd0, active}, 32'd1);
    check({v.name, "_rst_v0"},     register_v0,     32'd0);
    reset = 1'b1;
    #1;
    check({v.name, "_fetch_addr"}, address, RV);
    @(negedge clk);
    check({v.name, "_active_after_rst"}, {31'd0, active}, 32'd1);
    wait_halt(v.name, 2000);
    check({v.name, "_v0"}, register_v0, v.exp_v0);
    repeat (3) begin
      @(negedge clk);
      check({v.name, "_halt_idle"}, {30'd0, read, write}, 32'd0);
    end
  endtask

  initial begin
    for (int k = 0; k < 7; k++) begin
      tbl[k].prog  = '0;
      tbl[k].stall = 0;
    end
    // sllv program: lui, lw, lw, jr $0, sllv in delay slot
    tbl[0].name = "sllv";
    tbl[0].prog[0] = 32'h3C08BFC0; tbl[0].prog[1] = 32'h8D09002C;
    tbl[0].prog[2] = 32'h8D0A0030; tbl[0].prog[3] = 32'h00000008;
    tbl[0].prog[4] = 32'h01491004; tbl[0].prog[11] = 32'h0000000F;
    tbl[0].prog[12] = 32'h00000004; tbl[0].exp_v0 = 32'h000000F0;
    // same program with a 3-cycle stall on every request
    tbl[1] = tbl[0];
    tbl[1].name = "sllv_stall"; tbl[1].stall = 3;
    // addiu wraparound to zero
    tbl[2].name = "addiu_wrap";
    tbl[2].prog[0] = 32'h2402FFFF; tbl[2].prog[1] = 32'h24420001;
    tbl[2].prog[2] = 32'h00000008; tbl[2].prog[3] = 32'h00000000;
    tbl[2].exp_v0 = 32'h00000000;
    // srav of 80000000 by 4, srav sitting in the delay slot
    tbl[3].name = "srav";
    tbl[3].prog[0] = 32'h3C098000; tbl[3].prog[1] = 32'h240A0004;
    tbl[3].prog[2] = 32'h00000008; tbl[3].prog[3] = 32'h01491007;
    tbl[3].exp_v0 = 32'hF8000000;
    // store then load round trip through memory word 12
    tbl[4].name = "sw_lw";
    tbl[4].prog[0] = 32'h3C08BFC0; tbl[4].prog[1] = 32'h3C091234;
    tbl[4].prog[2] = 32'h35295678; tbl[4].prog[3] = 32'hAD090030;
    tbl[4].prog[4] = 32'h8D020030; tbl[4].prog[5] = 32'h00000008;
    tbl[4].exp_v0 = 32'h12345678;
    // beq taken: delay slot adds 1, skipped word would add 0x100
    tbl[5].name = "beq_delay";
    tbl[5].prog[0] = 32'h24020005; tbl[5].prog[1] = 32'h10000002;
    tbl[5].prog[2] = 32'h24420001; tbl[5].prog[3] = 32'h24420100;
    tbl[5].prog[4] = 32'h00000008; tbl[5].exp_v0 = 32'h00000006;
    // jal link value copied to v0, skipped word never runs
    tbl[6].name = "jal_link";
    tbl[6].prog[0] = 32'h0FF00003; tbl[6].prog[1] = 32'h00000000;
    tbl[6].prog[2] = 32'h24020077; tbl[6].prog[3] = 32'h03E01021;
    tbl[6].prog[4] = 32'h00000008; tbl[6].exp_v0 = 32'hBFC00008;

    for (int k = 0; k < 7; k++) run_vec(tbl[k]);

    // slt/sltu/sll/or combination: v0 = (1<<4) | 1
    begin
      vec_t v;
      v.name = "slt_sltu"; v.prog = '0; v.stall = 0;
      v.prog[0] = 32'h2409FFFF; v.prog[1] = 32'h0009502B;
      v.prog[2] = 32'h0120582A; v.prog[3] = 32'h000A5100;
      v.prog[4] = 32'h014B1025; v.prog[5] = 32'h00000008;
      v.exp_v0 = 32'h00000011;
      run_vec(v);
    end

    // Reset asserted while the first load is on the bus, then full rerun.
    begin
      int n;
      logic found;
      found = 1'b0;
      @(negedge clk);
      image = tbl[0].prog; stall_n = 0; load = 1'b1; reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      load = 1'b0; reset = 1'b1;
      n = 0;
      while (!found && n < 200) begin
        @(negedge clk);
        if (read && address == 32'hBFC0002C) found = 1'b1;
        n++;
      end
      check("midrst_load_seen", {31'd0, found}, 32'd1);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midrst_read_drop",  {31'd0, read},   32'd0);
      check("midrst_write_drop", {31'd0, write},  32'd0);
      check("midrst_active",     {31'd0, active}, 32'd1);
      reset = 1'b1;
      #1;
      check("midrst_restart_addr", address, RV);
      check("midrst_restart_read", {31'd0, read}, 32'd1);
      wait_halt("midrst", 2000);
      check("midrst_v0", register_v0, 32'h000000F0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/mips_cpu_bus.md
Name: mips_cpu_bus

Overview:
- Multi-cycle, non-pipelined MIPS-I subset CPU with a single shared instruction/data memory bus (Avalon-style: read/write/waitrequest/byteenable).
- Fetches from reset vector 0xBFC00000 and honours one branch delay slot.
- Halts when execution jumps to address 0.
- Exposes $v0 for test observation; top-level CPU block of the system.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-low reset
- active  output  1  high while CPU is running; low once halted
- register_v0  output  32  combinational copy of GPR $2
- address  output  32  byte address of current bus transaction, always word-aligned
- write  output  1  write request
- read  output  1  read request
- waitrequest  input  1  slave stall; transaction held while high
- writedata  output  32  store data
- byteenable  output  4  byte lanes of transaction; 4'b1111 for all word accesses
- readdata  input  32  read data, valid in cycle after accepted read

Behaviour:
- Reset (reset==0 at posedge clk):
  - PC=RESET_VECTOR; delay-slot/branch-pending state cleared.
  - All 32 GPRs=0; state=FETCH; active=1.
  - read=0, write=0.
- Bus rules:
  - read and write never both high.
  - A request is accepted on a clock edge where it is high and waitrequest==0.
  - While waitrequest==1, address, write, writedata, byteenable and read are held stable.
  - readdata is sampled in the cycle after acceptance.
- States:
  - FETCH: read=1, address=PC. On acceptance go to EXEC.
  - EXEC: latch instruction from readdata; decode; ALU op; GPR writeback for non-memory instructions. Loads/stores go to MEM; others go to FETCH.
  - MEM: issue read or write at base+sign-extended offset. Store: go to FETCH once accepted. Load: go to WB once accepted.
  - WB: write readdata to rt; go to FETCH.
  - HALT: no bus activity, active=0, remain until reset.
- Supported instructions:
  - R-type: addu, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, sllv, srlv, srav, jr, jalr.
  - I-type: addiu, andi, ori, xori, slti, sltiu, lui, lw, sw, beq, bne.
  - J-type: j, jal.
  - Unsupported opcodes execute as no-op.
- Width and arithmetic rules:
  - addu/subu/addiu wrap modulo 2^32, no overflow trap.
  - andi/ori/xori zero-extend imm; others sign-extend.
  - Shift amounts: sllv/srlv/srav use rs[4:0]; sll/srl/sra use shamt.
  - slt signed compare; sltu unsigned compare.
  - lui puts imm into [31:16], zeros into [15:0].
- $0 is hard-wired: writes ignored, always reads 0.
- Link and delay slot:
  - jal/jalr link PC+8; jal links into $31, jalr into rd.
- Control flow:
  - Jumps and taken branches set a pending target; the next sequential instruction (delay slot) always executes; then PC=target.
  - Branch target = PC+4+(sext(imm)<<2).
  - j/jal target = {PC+4[31:28], idx, 2'b00}.
- Halt:
  - When the post-delay-slot PC equals 0, enter HALT instead of fetching.
  - The delay-slot instruction's result, including a load or store, completes before HALT.
  - active falls in the same cycle HALT is entered.
- Reset mid-operation: an outstanding request is dropped (read/write low on the next cycle) and the CPU restarts from RESET_VECTOR.

Test Plan:
- sllv program (all values hex):
  - Memory (words at RESET_VECTOR): 3C08BFC0, 8D09002C, 8D0A0030, 00000008, 01491004; word 11=0000000F, word 12=00000004.
  - Required: active=1 the cycle after reset is released; ends with active=0 and register_v0=000000F0.
  - Confirms lui, lw, jr $0, delay-slot sllv and halt.
- waitrequest stall: hold waitrequest=1 for 3 cycles on each read -> address/read stable during the stall; final v0 still 000000F0.
- Arithmetic: addiu $2,$0,-1 then addiu $2,$2,1 before jr $0 -> v0=00000000. Also srav of 80000000 by 4 -> v0=F8000000.
- Store/load round trip: sw of 12345678 followed by lw to $2 -> v0=12345678; during the write cycle byteenable=1111.
- Branch delay slot: beq $0,$0 skipping one instruction, with addiu $2,$2,1 in the delay slot -> delay slot executes exactly once; skipped instruction never executes.
- Reset mid-run: assert reset during a load -> PC restarts at BFC00000, GPRs=0, program reruns to the correct v0.
